mvm_feeder: RTL and testbench

Matrix-vector sequencer that drives the saturating 12-bit `mac` unit. It loads an M×N signed matrix and an N-element signed vector through a valid/ready input stream. It then issues one dot product per row to the MAC's `a`/`b`/`valid_in` port, collects the 24-bit result when the MAC's `valid_out` returns, and streams the M results out through a valid/ready output port. It sits between the memory-load path and the downstream result consumer, and is the initiator side of the MAC operand interface.

---
 rtl/mvm_pkg.sv | 16 +
 rtl/mvm_store.sv | 39 +++
 rtl/mvm_feeder.sv | 152 +++++++++++++++
 tb/tb_mvm_feeder.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mvm_pkg.sv
// rtl/mvm_pkg.sv - shared state encoding and constants for the matrix-vector feeder
package mvm_pkg;

    typedef enum logic [2:0] {
        CLEAR,
        LOAD,
        ISSUE,
        DRAIN,
        OUT
    } state_t;

    localparam int MAC_LATENCY = 4;
    localparam int SAT_MAX     = 8388607;
    localparam int SAT_MIN     = -8388608;

endpackage

// File: rtl/mvm_store.sv
// rtl/mvm_store.sv - matrix/vector register file: one write port, combinational row/column read
module mvm_store
    import mvm_pkg::*;
#(
    parameter int M  = 4,
    parameter int N  = 4,
    parameter int W  = 12,
    parameter int AW = 5,
    parameter int RW = 2,
    parameter int CW = 2
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [RW-1:0] rd_row,
    input  logic [CW-1:0] rd_col,
    output logic [W-1:0]  rd_a,
    output logic [W-1:0]  rd_b
);

    // Matrix occupies words 0..M*N-1 row-major; the vector follows at M*N.
    logic [W-1:0]  mem [0:(1<<AW)-1];
    logic [AW-1:0] a_idx;
    logic [AW-1:0] b_idx;

    assign a_idx = AW'(int'(rd_row) * N + int'(rd_col));
    assign b_idx = AW'(M * N + int'(rd_col));

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rd_a = mem[a_idx];
    assign rd_b = mem[b_idx];

endmodule

// File: rtl/mvm_feeder.sv
// rtl/mvm_feeder.sv - matrix-vector sequencer for a saturating MAC; MVM_KEEP_MATRIX_EN reuses the loaded matrix
module mvm_feeder
    import mvm_pkg::*;
#(
    parameter int M = 4,
    parameter int N = 4,
    parameter int W = 12
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [W-1:0]   s_data,
    input  logic           s_valid,
    output logic           s_ready,
    output logic [W-1:0]   mac_a,
    output logic [W-1:0]   mac_b,
    output logic           mac_valid,
    output logic           mac_clear,
    input  logic [2*W-1:0] mac_f,
    input  logic           mac_valid_out,
    output logic [2*W-1:0] m_data,
    output logic           m_valid,
    input  logic           m_ready
);

    localparam int DEPTH = M * N + N;
    localparam int AW    = $clog2(DEPTH);
    localparam int RW    = (M > 1) ? $clog2(M) : 1;
    localparam int CW    = (N > 1) ? $clog2(N) : 1;

    state_t        state;
    logic [AW-1:0] wr_idx;
    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic [CW-1:0] pulses;
    logic [W-1:0]  rd_a;
    logic [W-1:0]  rd_b;
    logic          wr_en;
`ifdef MVM_KEEP_MATRIX_EN
    logic          have_matrix;
`endif

    assign wr_en = (state == LOAD) && s_valid && s_ready;

    mvm_store #(
        .M (M),
        .N (N),
        .W (W),
        .AW(AW),
        .RW(RW),
        .CW(CW)
    ) u_store (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_idx),
        .wdata (s_data),
        .rd_row(row),
        .rd_col(col),
        .rd_a  (rd_a),
        .rd_b  (rd_b)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= CLEAR;
            wr_idx    <= '0;
            row       <= '0;
            col       <= '0;
            pulses    <= '0;
            s_ready   <= 1'b0;
            mac_valid <= 1'b0;
            mac_a     <= '0;
            mac_b     <= '0;
            mac_clear <= 1'b1;
            m_valid   <= 1'b0;
            m_data    <= '0;
`ifdef MVM_KEEP_MATRIX_EN
            have_matrix <= 1'b0;
`endif
        end else begin
            mac_clear <= 1'b0;
            mac_valid <= 1'b0;
            unique case (state)
                CLEAR: begin
                    row     <= '0;
                    col     <= '0;
                    pulses  <= '0;
`ifdef MVM_KEEP_MATRIX_EN
                    wr_idx  <= have_matrix ? AW'(M * N) : '0;
`else
                    wr_idx  <= '0;
`endif
                    s_ready <= 1'b1;
                    state   <= LOAD;
                end
                LOAD: begin
                    if (wr_en) begin
                        if (wr_idx == AW'(DEPTH - 1)) begin
                            s_ready <= 1'b0;
                            state   <= ISSUE;
`ifdef MVM_KEEP_MATRIX_EN
                            have_matrix <= 1'b1;
`endif
                        end else begin
                            wr_idx <= wr_idx + 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    mac_valid <= 1'b1;
                    mac_a     <= rd_a;
                    mac_b     <= rd_b;
                    // With N > MAC latency, early results return while still issuing.
                    if (mac_valid_out) begin
                        pulses <= pulses + 1'b1;
                    end
                    if (col == CW'(N - 1)) begin
                        col   <= '0;
                        state <= DRAIN;
                    end else begin
                        col <= col + 1'b1;
                    end
                end
                DRAIN: begin
                    if (mac_valid_out) begin
                        if (pulses == CW'(N - 1)) begin
                            m_data  <= mac_f;
                            m_valid <= 1'b1;
                            state   <= OUT;
                        end else begin
                            pulses <= pulses + 1'b1;
                        end
                    end
                end
                OUT: begin
                    if (m_ready) begin
                        m_valid   <= 1'b0;
                        mac_clear <= 1'b1;
                        pulses    <= '0;
                        if (row == RW'(M - 1)) begin
                            state <= CLEAR;
                        end else begin
                            row   <= row + 1'b1;
                            state <= ISSUE;
                        end
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

endmodule

// File: tb/tb_mvm_feeder.sv
// tb/tb_mvm_feeder.sv - self-checking bench for mvm_feeder with a behavioural saturating MAC
module tb_mvm_feeder;
    import mvm_pkg::*;

    localparam int M = 4;
    localparam int N = 4;
    localparam int W = 12;

    logic          clk = 1'b0;
    logic          reset;
    logic [W-1:0]  s_data;
    logic          s_valid;
    logic          s_ready;
    logic [W-1:0]  mac_a;
    logic [W-1:0]  mac_b;
    logic          mac_valid;
    logic          mac_clear;
    logic [2*W-1:0] mac_f;
    logic          mac_valid_out;
    logic [2*W-1:0] m_data;
    logic          m_valid;
    logic          m_ready;

    mvm_feeder #(.M(M), .N(N), .W(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .mac_a        (mac_a),
        .mac_b        (mac_b),
        .mac_valid    (mac_valid),
        .mac_clear    (mac_clear),
        .mac_f        (mac_f),
        .mac_valid_out(mac_valid_out),
        .m_data       (m_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] sat24(input longint v);
        if (v > SAT_MAX) return 24'(SAT_MAX);
        if (v < SAT_MIN) return 24'(SAT_MIN);
        return 24'(v);
    endfunction

    // Saturating MAC: result and valid_out appear MAC_LATENCY cycles after valid_in, counting the issue cycle.
    logic signed [23:0] acc_q = '0;
    logic [23:0] mac_next;
    logic [2:0]  pv = '0;
    logic [23:0] pf0 = '0, pf1 = '0, pf2 = '0;
    assign mac_next = sat24(longint'(acc_q) + longint'($signed(mac_a)) * longint'($signed(mac_b)));
    always @(posedge clk) begin
        if (mac_clear) begin
            acc_q <= '0;
            pv    <= '0;
        end else begin
            pv  <= {pv[1:0], mac_valid};
            pf1 <= pf0;
            pf2 <= pf1;
            if (mac_valid) begin
                acc_q <= mac_next;
                pf0   <= mac_next;
            end
        end
    end
    assign mac_valid_out = pv[2];
    assign mac_f         = pf2;

    int   cyc = 0;
    int   first_mv = 0;
    logic mv_prev = 1'b0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (mac_valid && !mv_prev) first_mv <= cyc;
        mv_prev <= mac_valid;
    end

    typedef struct packed {
        logic [15:0][11:0] a;
        logic [3:0][11:0]  x;
        logic [3:0][23:0]  e;
    } vec_t;
    vec_t tbl [4];

    int n_vec = 0;
    int n_bad = 0;
    logic signed [11:0] cur_a [M*N];
    logic signed [11:0] cur_x [N];
    logic signed [23:0] exp_r [M];
    logic [11:0]        wbuf  [M*N+N];
`ifdef MVM_KEEP_MATRIX_EN
    bit matrix_loaded = 0;
`endif

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] rnd12();
        case ($urandom % 4)
            0:       return 12'h7FF;
            1:       return 12'h800;
            default: return 12'($urandom_range(0, 4095));
        endcase
    endfunction

    function automatic logic signed [23:0] dot_sat(input int r);
        longint acc = 0;
        for (int k = 0; k < N; k++) begin
            acc = acc + longint'(cur_a[r*N+k]) * longint'(cur_x[k]);
            if (acc > SAT_MAX) acc = SAT_MAX;
            if (acc < SAT_MIN) acc = SAT_MIN;
        end
        return 24'(acc);
    endfunction

    task automatic do_reset();
        reset = 1'b0;
        #1;
        chk("reset_vals", {12'd0, s_ready, mac_valid, mac_a, mac_b, m_valid, m_data, mac_clear},
            {12'd0, 1'b0, 1'b0, 12'd0, 12'd0, 1'b0, 24'd0, 1'b1});
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("clear_one_cycle", {mac_clear, s_ready}, 2'b01);
`ifdef MVM_KEEP_MATRIX_EN
        matrix_loaded = 0;
`endif
    endtask

    task automatic load_words(input int first, input bit rv);
        int cnt = M*N + N - first;
        int idx = 0;
        int guard = 0;
        while (idx < cnt && guard < 1000) begin
            @(negedge clk);
            guard++;
            s_valid = rv ? 1'($urandom % 2) : 1'b1;
            s_data  = s_valid ? wbuf[first+idx] : 12'($urandom);
            if (s_valid && s_ready) idx++;
        end
        chk("load_count", idx, cnt);
        if (!rv) chk("load_nobubble", guard, cnt);
        @(negedge clk);
        s_valid = 1'b0;
        chk("sready_drop", s_ready, 0);
    endtask

    task automatic collect(input bit rr, input int hold_row);
        int r = 0, guard = 0, hold_cnt = 0, hold_bad = 0, sready_bad = 0;
        bit seen = 0, pend = 0;
        logic [23:0] held = '0;
        while (r < M && guard < 400) begin
            @(negedge clk);
            guard++;
            if (pend) begin
                chk("clear_pulse", {mac_clear, m_valid, mac_valid}, 3'b100);
                pend = 0;
            end
            s_valid = 1'($urandom % 2);
            s_data  = 12'($urandom);
            if (s_ready) sready_bad++;
            if (m_valid && !seen) begin
                seen = 1;
                hold_cnt = 0;
                held = m_data;
                chk("mvalid_latency", cyc - first_mv, N + MAC_LATENCY - 1);
            end
            if (r == hold_row && seen && hold_cnt < 10) begin
                m_ready = 1'b0;
                if (m_valid !== 1'b1 || m_data !== held || mac_valid !== 1'b0) hold_bad++;
                hold_cnt++;
            end else begin
                m_ready = rr ? 1'($urandom % 2) : 1'b1;
            end
            if (m_valid && m_ready) begin
                chk("m_data", {40'd0, m_data}, {40'd0, exp_r[r]});
                r++;
                seen = 0;
                pend = 1;
            end
        end
        chk("collect_rows", r, M);
        @(negedge clk);
        s_valid = 1'b0;
        m_ready = 1'b1;
        if (pend) chk("clear_pulse", {mac_clear, m_valid, mac_valid}, 3'b100);
        chk("sready_outside_load", sready_bad, 0);
        if (hold_row >= 0) chk("hold_stable", hold_bad, 0);
    endtask

    task automatic fill_wbuf();
        for (int i = 0; i < M*N; i++) wbuf[i] = cur_a[i];
        for (int k = 0; k < N; k++) wbuf[M*N+k] = cur_x[k];
    endtask

    task automatic run_job(input bit rv, input bit rr, input int hold_row);
        int first = 0;
`ifdef MVM_KEEP_MATRIX_EN
        if (matrix_loaded) first = M*N;
`endif
        fill_wbuf();
        load_words(first, rv);
`ifdef MVM_KEEP_MATRIX_EN
        matrix_loaded = 1;
`endif
        collect(rr, hold_row);
    endtask

    task automatic use_tbl(input int t);
        for (int i = 0; i < M*N; i++) cur_a[i] = tbl[t].a[i];
        for (int k = 0; k < N; k++) cur_x[k] = tbl[t].x[k];
        for (int r = 0; r < M; r++) exp_r[r] = tbl[t].e[r];
    endtask

    initial begin
        reset   = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b1;

        tbl[0] = '0;
        tbl[0].a[0] = 12'd1;  tbl[0].a[1] = 12'd2;
        tbl[0].a[4] = 12'd3;  tbl[0].a[5] = 12'd4;
        tbl[0].x[0] = 12'd5;  tbl[0].x[1] = 12'd6;
        tbl[0].e[0] = 24'd17; tbl[0].e[1] = 24'd39;
        for (int t = 1; t < 4; t++) tbl[t] = '0;
        for (int i = 0; i < 16; i++) begin
            tbl[1].a[i] = 12'd2047;
            tbl[2].a[i] = 12'hFFF - 12'd2047;
            tbl[3].a[i] = 12'(i / 4 + 1);
        end
        for (int k = 0; k < 4; k++) begin
            tbl[1].x[k] = 12'd2047;
            tbl[2].x[k] = 12'd2047;
            tbl[3].x[k] = 12'(k + 1);
            tbl[1].e[k] = 24'd8388607;
            tbl[2].e[k] = 24'h800000;
            tbl[3].e[k] = 24'(10 * (k + 1));
        end

        #2;
        for (int t = 0; t < 4; t++) begin
            do_reset();
            use_tbl(t);
            run_job(1'b0, 1'b0, (t == 0) ? 1 : -1);
        end

        begin
            int guard = 0, hs = 0;
            bit started = 0;
            do_reset();
            use_tbl(1);
            fill_wbuf();
            load_words(0, 1'b0);
            m_ready = 1'b1;
            while (guard < 200 && !started) begin
                @(negedge clk);
                guard++;
                if (hs == 1 && mac_valid) started = 1;
                else if (m_valid && m_ready) hs++;
            end
            chk("mid_issue_reached", started, 1);
            do_reset();
            use_tbl(3);
            run_job(1'b0, 1'b0, -1);
        end

`ifdef MVM_KEEP_MATRIX_EN
        do_reset();
        use_tbl(0);
        run_job(1'b0, 1'b0, -1);
        for (int k = 0; k < N; k++) cur_x[k] = (k < 2) ? 12'sd1 : 12'sd0;
        exp_r[0] = 24'sd3;
        exp_r[1] = 24'sd7;
        exp_r[2] = 24'sd0;
        exp_r[3] = 24'sd0;
        run_job(1'b0, 1'b0, -1);
`endif

        for (int j = 0; j < 8; j++) begin
            bit new_a = 1;
`ifdef MVM_KEEP_MATRIX_EN
            new_a = !matrix_loaded;
`endif
            if (new_a) for (int i = 0; i < M*N; i++) cur_a[i] = rnd12();
            for (int k = 0; k < N; k++) cur_x[k] = rnd12();
            for (int r = 0; r < M; r++) exp_r[r] = dot_sat(r);
            run_job(1'b1, 1'b1, (j == 2) ? int'($urandom_range(0, M-1)) : -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
